button_event_arbiter: RTL
=========================

# button_event_arbiter

Classifies presses on up to `NUM_BUTTONS` debounced button lines as short or long. Queues one pending event per button and hands events one at a time to a single consumer, such as the control FSM or a UART reporter, over a valid/ready handshake. Buttons are granted in round-robin order. The block sits between the per-button debouncer outputs and the design's command logic, so that one consumer services every front-panel button.

## Interface
- `NUM_BUTTONS`, 4: number of button inputs, 2..16.
- `CLK_PERIOD_NS`, 5: clock period; sets the 1 ms tick, `TICK_CYCLES = 1_000_000 / CLK_PERIOD_NS`.
- `LONG_PRESS_MS`, 1000: hold time in ms at which a press becomes a long press; must be ≥ 1.
- `ID_W`, `$clog2(NUM_BUTTONS)`: derived width of the button index.

- `clk`  in  1  system clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `btn_level`  in  `NUM_BUTTONS`  debounced button levels, 1 = pressed.
- `evt_valid`  out  1  an event is presented.
- `evt_ready`  in  1  consumer accepts the event when `evt_valid && evt_ready`.
- `evt_id`  out  `ID_W`  index of the button that produced the event.
- `evt_long`  out  1  1 = long press, 0 = short press.
- `dropped`  out  `NUM_BUTTONS`  sticky per-button flag: an event was lost because one was already pending.

## Operation
- **Reset values:** all of these clear to 0.
  - Outputs: `evt_valid`, `evt_id`, `evt_long`, `dropped`.
  - Internal state: tick counter, `btn_prev`, hold counters, `long_fired`, `pending`, `pending_long`, `rr_ptr`.
- **Tick counter:** free-running from 0 to `TICK_CYCLES-1`. It asserts `tick` for one cycle when it wraps.
- **Per-button tracking:**
  - `btn_prev[i]` registers `btn_level[i]`.
  - While `btn_level[i]` = 1:
    - The hold counter increments on `tick`.
    - The counter saturates at `LONG_PRESS_MS` and is `$clog2(LONG_PRESS_MS+1)` bits wide.
  - While `btn_level[i]` = 0, the hold counter and `long_fired[i]` clear.
- **Long event:**
  - Fires in the cycle where the hold counter becomes equal to `LONG_PRESS_MS` while `long_fired[i]` = 0.
  - The same cycle sets `long_fired[i]`.
- **Short event:** fires on the release cycle (`btn_prev[i]`=1, `btn_level[i]`=0) when `long_fired[i]` = 0. This includes releases before any tick.
- **Release after a long press:** no event.
- **Posting an event:**
  - If `pending[i]` = 0: set `pending[i]` and load `pending_long[i]`.
  - If `pending[i]` = 1 and it is not being granted that cycle: drop the new event and set `dropped[i]`.
  - `dropped` clears only on reset.
- **Output register:** loads when `!evt_valid || evt_ready`.
  - If any `pending` bit is set, the winner is the first set bit searching upward from `rr_ptr` with wrap-around. Load `evt_id`/`evt_long`, set `evt_valid`, clear `pending[winner]`, and set `rr_ptr = (winner+1) mod NUM_BUTTONS`.
  - Otherwise `evt_valid` goes to 0.
- **Same-button grant and new event in one cycle:** the new event is posted into `pending` (set wins over clear) and is not dropped.
- **Stability while stalled:** `evt_id` and `evt_long` hold stable while `evt_valid && !evt_ready`.

## Timing
- **Short-press latency:**
  - Release seen at `btn_level` in cycle t.
  - `pending` is set at t+1.
  - `evt_valid` is asserted at t+2 if the output register is free or accepted at t+1.
- **Long-press latency:** counter reaches threshold in cycle t → `evt_valid` at t+2 under the same conditions.
- **Hold-time resolution:** the tick is not phase-aligned to the press, so hold time resolves to between `LONG_PRESS_MS-1` and `LONG_PRESS_MS` ms.
- **Throughput:** one event per cycle when `evt_ready` is held high.
- **Reset mid-operation:**
  - Clears queued and presented events.
  - A button held through reset is treated as newly pressed on the first cycle after reset and is timed from there.
- **Inputs:** `btn_level` must already be synchronous to `clk`; the block adds no synchronizer.

## Test plan
Common parameters: `NUM_BUTTONS`=4, `CLK_PERIOD_NS`=100000 (`TICK_CYCLES`=10), `LONG_PRESS_MS`=3, `evt_ready`=1 unless stated.

1. **Short press:** button 2 high for 15 cycles, then low → exactly one event `evt_id`=2, `evt_long`=0; `evt_valid` rises 2 cycles after the release cycle and stays high for 1 cycle.
2. **Long press:** button 1 held 60 cycles → one event `evt_id`=1, `evt_long`=1 within 2 cycles of the third tick during the hold, with no further event on release.
3. **Round-robin and stall:**
   - Buttons 0, 1 and 3 are released in the same cycle with `evt_ready`=0.
   - Then `evt_ready`=1.
   - Required: grants in order 0, 1, 3 with ids stable during the stall.
   - A repeat of the simultaneous release then grants in order 0, 1, 3 again (`rr_ptr` is 0 after granting 3).
4. **Drop:** `evt_ready`=0; button 0 is pressed and released twice. The first event is presented and not accepted; the second is posted to `pending`. A third press/release finds `pending[0]` still set, so it is dropped and `dropped`=4'b0001. After `evt_ready`=1, exactly two events are delivered.
5. **Same-button grant and new event:** button 2's release is timed so its post coincides with the grant of button 2's earlier pending event → both events delivered, `dropped`=0.
6. **Reset mid-operation:** `sys_rst` is pulsed for 1 cycle with `evt_valid`=1 and pending bits set → next cycle all outputs are 0. A button held through reset produces a long event 3 ticks later.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Classifies short/long presses on debounced button lines, holds one pending
// event per button and presents them round-robin over a valid/ready handshake.
module button_event_arbiter #(
  parameter int NUM_BUTTONS   = 4,
  parameter int CLK_PERIOD_NS = 5,
  parameter int LONG_PRESS_MS = 1000,
  parameter int ID_W          = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic [NUM_BUTTONS-1:0] btn_level,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [ID_W-1:0]        evt_id,
  output logic                   evt_long,
  output logic [NUM_BUTTONS-1:0] dropped
);

  localparam int TICK_CYCLES = 1_000_000 / CLK_PERIOD_NS;
  localparam int TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HOLD_W      = $clog2(LONG_PRESS_MS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_MS);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_BUTTONS - 1);

  logic [TICK_W-1:0]      tick_cnt;
  logic                   tick;

  logic [HOLD_W-1:0]      hold_cnt [NUM_BUTTONS];
  logic [HOLD_W-1:0]      hold_nxt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] btn_prev;
  logic [NUM_BUTTONS-1:0] long_fired;
  logic [NUM_BUTTONS-1:0] long_evt;
  logic [NUM_BUTTONS-1:0] short_evt;
  logic [NUM_BUTTONS-1:0] post;

  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] pending_long;
  logic [NUM_BUTTONS-1:0] accept;
  logic [NUM_BUTTONS-1:0] drop;
  logic [NUM_BUTTONS-1:0] grant;

  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        rr_nxt;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        scan_idx;
  logic                   found;
  logic                   load;

  // 1 ms time base
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Long fires in the cycle the hold count reaches threshold, not one later
  always_comb begin
    long_evt  = '0;
    short_evt = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      hold_nxt[i] = hold_cnt[i];
      if (!btn_level[i]) begin
        hold_nxt[i] = '0;
      end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
        hold_nxt[i] = hold_cnt[i] + HOLD_W'(1);
      end
      long_evt[i]  = btn_level[i] && !long_fired[i] && (hold_nxt[i] == HOLD_MAX);
      short_evt[i] = btn_prev[i] && !btn_level[i] && !long_fired[i];
    end
  end

  assign post = long_evt | short_evt;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      btn_prev   <= '0;
      long_fired <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      btn_prev <= btn_level;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        hold_cnt[i] <= hold_nxt[i];
        if (!btn_level[i]) begin
          long_fired[i] <= 1'b0;
        end else if (long_evt[i]) begin
          long_fired[i] <= 1'b1;
        end
      end
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_BUTTONS
  assign load = !evt_valid || evt_ready;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      if ((int'(rr_ptr) + k) >= NUM_BUTTONS) begin
        scan_idx = ID_W'(int'(rr_ptr) + k - NUM_BUTTONS);
      end else begin
        scan_idx = ID_W'(int'(rr_ptr) + k);
      end
      if (!found && pending[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
    grant = '0;
    if (load && found) begin
      grant[winner] = 1'b1;
    end
    rr_nxt = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
  end

  // A post into a slot that is being granted this cycle is accepted, not dropped
  assign accept = post & (~pending | grant);
  assign drop   = post & pending & ~grant;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pending      <= '0;
      pending_long <= '0;
      dropped      <= '0;
    end else begin
      pending      <= (pending & ~grant) | accept;
      pending_long <= (pending_long & ~accept) | (long_evt & accept);
      dropped      <= dropped | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_long  <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_id   <= winner;
        evt_long <= pending_long[winner];
        rr_ptr   <= rr_nxt;
      end
    end
  end

endmodule
